// File: rtl/cci_rd_req_arb_pkg.sv
// Shared types and mdata helpers for the c0 read-request arbiter.
// Optional statistics are enabled with CCI_RD_REQ_ARB_STATS_EN (see top).
package cci_rd_req_arb_pkg;

    localparam int unsigned ARB_ID_W = 3;
    localparam int unsigned MDATA_W  = 16;

    typedef logic [ARB_ID_W-1:0]         t_req_id;
    typedef logic [MDATA_W-ARB_ID_W-1:0] t_local_tag;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        IDLE
    } t_arb_state;

    // Place the requester ID in the top id_w bits of mdata, local tag below it.
    function automatic logic [15:0] pack_mdata(input logic [7:0]  id,
                                               input logic [15:0] tag,
                                               input int unsigned id_w);
        logic [15:0] mask;
        mask = 16'hFFFF >> id_w;
        return (16'(id) << (16 - id_w)) | (tag & mask);
    endfunction

    // Recover the requester ID from the top id_w bits of mdata.
    function automatic logic [7:0] unpack_id(input logic [15:0] mdata,
                                             input int unsigned id_w);
        return 8'(mdata >> (16 - id_w));
    endfunction

endpackage

// File: rtl/cci_rr_picker.sv
// Rotate-priority picker: first eligible requester at or after ptr, wrapping.
// Purely combinational; the pointer register lives in the parent.
module cci_rr_picker #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 3
) (
    input  logic [NUM_REQ-1:0] eligible_i,
    input  logic [ID_W-1:0]    ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [ID_W-1:0]    grant_id_o,
    output logic               grant_any_o
);

    localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic        found;
    int unsigned idx;

    // Scan from ptr upward, wrapping, and take the first eligible entry.
    always_comb begin
        grant_o    = '0;
        grant_id_o = '0;
        found      = 1'b0;
        idx        = 0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            idx = (32'(ptr_i) + off) % NUM_REQ;
            if (!found && eligible_i[idx[IW-1:0]]) begin
                found                 = 1'b1;
                grant_o[idx[IW-1:0]]  = 1'b1;
                grant_id_o            = ID_W'(idx);
            end
        end
        grant_any_o = found;
    end

endmodule

// File: rtl/cci_rd_req_arbiter.sv
// Round-robin arbiter sharing the c0 read-request channel among NUM_REQ
// engines: tags mdata with the requester ID, routes responses back by ID,
// enforces a per-requester outstanding-read limit and offers a drain handshake.
// Define CCI_RD_REQ_ARB_STATS_EN to add grant/stall statistics outputs.
module cci_rd_req_arbiter
    import cci_rd_req_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ         = 4,
    parameter int unsigned ID_W            = 3,
    parameter int unsigned ADDR_W          = 42,
    parameter int unsigned MAX_OUTSTANDING = 64
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0]     req_addr,
    input  logic [NUM_REQ*(16-ID_W)-1:0]  req_tag,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          tx_valid,
    output logic [ADDR_W-1:0]             tx_addr,
    output logic [15:0]                   tx_mdata,
    input  logic                          tx_almostFull,
    input  logic                          rx_valid,
    input  logic [15:0]                   rx_mdata,
    input  logic [511:0]                  rx_data,
    output logic [NUM_REQ-1:0]            resp_valid,
    output logic [16-ID_W-1:0]            resp_tag,
    output logic [511:0]                  resp_data,
    input  logic                          drain_req,
    output logic                          drained,
    output logic                          tag_err
`ifdef CCI_RD_REQ_ARB_STATS_EN
    ,
    output logic [NUM_REQ*32-1:0]         stat_grants,
    output logic [31:0]                   stat_stall
`endif
);

    localparam int unsigned TAG_W = 16 - ID_W;
    localparam int unsigned CW    = $clog2(MAX_OUTSTANDING) + 1;

    t_arb_state          state_q, state_d;
    logic [ID_W-1:0]     ptr_q, ptr_d;

    logic                grant_en;
    logic [NUM_REQ-1:0]  eligible;
    logic [NUM_REQ-1:0]  grant;
    logic [ID_W-1:0]     grant_id;
    logic                grant_any;

    logic [ADDR_W-1:0]   sel_addr;
    logic [TAG_W-1:0]    sel_tag;

    logic                tx_valid_q;
    logic [ADDR_W-1:0]   tx_addr_q;
    logic [15:0]         tx_mdata_q;

    logic [7:0]          rx_id;
    logic                rx_id_ok;
    logic [NUM_REQ-1:0]  rx_hit;
    logic [NUM_REQ-1:0]  underflow;
    logic [NUM_REQ-1:0]  cnt_nz;

    logic [NUM_REQ-1:0]  resp_valid_q;
    logic [TAG_W-1:0]    resp_tag_q;
    logic [511:0]        resp_data_q;
    logic                tag_err_q;
    logic                drained_c;

    // Reset also gates grants so req_ready reads 0 while reset is held.
    assign grant_en = (state_q == RUN) && !drain_req && !tx_almostFull && !reset;

    assign rx_id    = unpack_id(rx_mdata, ID_W);
    assign rx_id_ok = (rx_id < 8'(NUM_REQ));

    cci_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_picker (
        .eligible_i  (eligible),
        .ptr_i       (ptr_q),
        .grant_o     (grant),
        .grant_id_o  (grant_id),
        .grant_any_o (grant_any)
    );

    assign req_ready = grant;

    // Per-requester credit counter, eligibility and response decode.
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_req
        logic [CW-1:0] cnt_q, cnt_d;
        logic          dec_ok;

        assign rx_hit[g]    = rx_valid && rx_id_ok && (rx_id == 8'(g));
        assign dec_ok       = rx_hit[g] && (cnt_q != '0);
        assign underflow[g] = rx_hit[g] && (cnt_q == '0);
        assign cnt_nz[g]    = (cnt_q != '0);
        assign eligible[g]  = req_valid[g] && (cnt_q < CW'(MAX_OUTSTANDING)) && grant_en;

        // Grant adds a credit, routed response returns one; both cancel out.
        always_comb begin
            cnt_d = cnt_q;
            if (grant[g] && !dec_ok) begin
                cnt_d = cnt_q + CW'(1);
            end else if (!grant[g] && dec_ok) begin
                cnt_d = cnt_q - CW'(1);
            end
        end

        // Credit counter register.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) cnt_q <= '0;
            else       cnt_q <= cnt_d;
        end
    end

    // Mux the granted requester's address and local tag.
    always_comb begin
        sel_addr = req_addr[32'(grant_id)*ADDR_W +: ADDR_W];
        sel_tag  = req_tag[32'(grant_id)*TAG_W +: TAG_W];
    end

    // Advance the round-robin pointer past the winner only when a grant occurs.
    always_comb begin
        ptr_d = ptr_q;
        if (grant_any) begin
            ptr_d = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
        end
    end

    // Pointer register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) ptr_q <= '0;
        else       ptr_q <= ptr_d;
    end

    // Registered Tx stage: valid for exactly one cycle after each grant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_valid_q <= 1'b0;
            tx_addr_q  <= '0;
            tx_mdata_q <= '0;
        end else begin
            tx_valid_q <= grant_any;
            if (grant_any) begin
                tx_addr_q  <= sel_addr;
                tx_mdata_q <= pack_mdata(8'(grant_id), 16'(sel_tag), ID_W);
            end
        end
    end

    // Registered response routing; unknown IDs are dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp_valid_q <= '0;
            resp_tag_q   <= '0;
            resp_data_q  <= '0;
        end else begin
            resp_valid_q <= rx_hit;
            if (rx_valid && rx_id_ok) begin
                resp_tag_q  <= rx_mdata[TAG_W-1:0];
                resp_data_q <= rx_data;
            end
        end
    end

    // Sticky error: unknown ID or a response with no credit outstanding.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) tag_err_q <= 1'b0;
        else       tag_err_q <= tag_err_q || (rx_valid && !rx_id_ok) || (|underflow);
    end

    // FSM next state and drained decode.
    always_comb begin
        state_d   = state_q;
        drained_c = 1'b0;
        unique case (state_q)
            RUN: begin
                if (drain_req) state_d = DRAIN;
            end
            DRAIN: begin
                if (!drain_req)                     state_d = RUN;
                else if (!(|cnt_nz) && !tx_valid_q) state_d = IDLE;
            end
            IDLE: begin
                drained_c = 1'b1;
                if (!drain_req) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= RUN;
        else       state_q <= state_d;
    end

    assign tx_valid   = tx_valid_q;
    assign tx_addr    = tx_addr_q;
    assign tx_mdata   = tx_mdata_q;
    assign resp_valid = resp_valid_q;
    assign resp_tag   = resp_tag_q;
    assign resp_data  = resp_data_q;
    assign drained    = drained_c;
    assign tag_err    = tag_err_q;

`ifdef CCI_RD_REQ_ARB_STATS_EN
    logic        stat_clr;
    logic [31:0] stall_q;

    assign stat_clr = (state_q == RUN) && (state_d == DRAIN);

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
        logic [31:0] grants_q;

        // Saturating per-requester grant counter.
        always_ff @(posedge clk or posedge reset) begin
            if (reset)                          grants_q <= '0;
            else if (stat_clr)                  grants_q <= '0;
            else if (grant[g] && grants_q != '1) grants_q <= grants_q + 32'd1;
        end

        assign stat_grants[g*32 +: 32] = grants_q;
    end

    // Saturating count of cycles where a pending request is held off by almostFull.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)         stall_q <= '0;
        else if (stat_clr) stall_q <= '0;
        else if ((state_q == RUN) && !drain_req && (|req_valid) && tx_almostFull && stall_q != '1)
            stall_q <= stall_q + 32'd1;
    end

    assign stat_stall = stall_q;
`endif

endmodule

// File: tb/tb_cci_rd_req_arbiter.sv
// Directed self-checking bench for cci_rd_req_arbiter (NUM_REQ=4, ID_W=3).
module tb_cci_rd_req_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 3;
    localparam int ADDR_W  = 42;
    localparam int MAXO    = 64;
    localparam int TAG_W   = 16 - ID_W;

    logic                         clk;
    logic                         reset;
    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ*ADDR_W-1:0]    req_addr;
    logic [NUM_REQ*TAG_W-1:0]     req_tag;
    logic [NUM_REQ-1:0]           req_ready;
    logic                         tx_valid;
    logic [ADDR_W-1:0]            tx_addr;
    logic [15:0]                  tx_mdata;
    logic                         tx_almostFull;
    logic                         rx_valid;
    logic [15:0]                  rx_mdata;
    logic [511:0]                 rx_data;
    logic [NUM_REQ-1:0]           resp_valid;
    logic [TAG_W-1:0]             resp_tag;
    logic [511:0]                 resp_data;
    logic                         drain_req;
    logic                         drained;
    logic                         tag_err;

    int checks = 0;
    int errors = 0;

    cci_rd_req_arbiter #(
        .NUM_REQ         (NUM_REQ),
        .ID_W            (ID_W),
        .ADDR_W          (ADDR_W),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_addr      (req_addr),
        .req_tag       (req_tag),
        .req_ready     (req_ready),
        .tx_valid      (tx_valid),
        .tx_addr       (tx_addr),
        .tx_mdata      (tx_mdata),
        .tx_almostFull (tx_almostFull),
        .rx_valid      (rx_valid),
        .rx_mdata      (rx_mdata),
        .rx_data       (rx_data),
        .resp_valid    (resp_valid),
        .resp_tag      (resp_tag),
        .resp_data     (resp_data),
        .drain_req     (drain_req),
        .drained       (drained),
        .tag_err       (tag_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [ADDR_W-1:0] addr_of(input int i);
        return ADDR_W'(42'h1000 * (i + 1) + 42'h5);
    endfunction

    function automatic logic [TAG_W-1:0] tag_of(input int i);
        return TAG_W'(13'h0100 + i);
    endfunction

    function automatic logic [15:0] md_of(input int i);
        return {3'(i), tag_of(i)};
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_bus();
        for (int i = 0; i < NUM_REQ; i++) begin
            req_addr[i*ADDR_W +: ADDR_W] = addr_of(i);
            req_tag[i*TAG_W +: TAG_W]    = tag_of(i);
        end
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        req_valid = '0; tx_almostFull = 1'b0; rx_valid = 1'b0;
        rx_mdata = '0; rx_data = '0; drain_req = 1'b0;
        next_cycle();
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_bus();
        req_valid = '1; tx_almostFull = 1'b0; drain_req = 1'b0;
        rx_valid = 1'b1; rx_mdata = 16'hA000; rx_data = '1;
        next_cycle();
        #1;
        checks++; if (req_ready !== 4'h0) begin errors++; $display("FAIL reset_req_ready: got %0h expected 0", req_ready); end
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %0b expected 0", tx_valid); end
        checks++; if (tx_addr !== '0) begin errors++; $display("FAIL reset_tx_addr: got %0h expected 0", tx_addr); end
        checks++; if (tx_mdata !== 16'h0) begin errors++; $display("FAIL reset_tx_mdata: got %0h expected 0", tx_mdata); end
        checks++; if (resp_valid !== 4'h0) begin errors++; $display("FAIL reset_resp_valid: got %0h expected 0", resp_valid); end
        checks++; if (resp_tag !== '0) begin errors++; $display("FAIL reset_resp_tag: got %0h expected 0", resp_tag); end
        checks++; if (resp_data !== '0) begin errors++; $display("FAIL reset_resp_data: got %0h expected 0", resp_data[31:0]); end
        checks++; if (drained !== 1'b0) begin errors++; $display("FAIL reset_drained: got %0b expected 0", drained); end
        checks++; if (tag_err !== 1'b0) begin errors++; $display("FAIL reset_tag_err: got %0b expected 0", tag_err); end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g;
        int         prev;
        apply_reset();
        req_valid = 4'hF;
        for (int k = 0; k < 8; k++) begin
            #1;
            exp_g = 4'(1 << (k % 4));
            checks++; if (req_ready !== exp_g) begin errors++; $display("FAIL rr_grant[%0d]: got %0h expected %0h", k, req_ready, exp_g); end
            if (k == 0) begin
                checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL rr_tx_first: got %0b expected 0", tx_valid); end
            end else begin
                prev = (k - 1) % 4;
                checks++; if (tx_valid !== 1'b1) begin errors++; $display("FAIL rr_tx_valid[%0d]: got %0b expected 1", k, tx_valid); end
                checks++; if (tx_mdata !== md_of(prev)) begin errors++; $display("FAIL rr_tx_mdata[%0d]: got %0h expected %0h", k, tx_mdata, md_of(prev)); end
                checks++; if (tx_addr !== addr_of(prev)) begin errors++; $display("FAIL rr_tx_addr[%0d]: got %0h expected %0h", k, tx_addr, addr_of(prev)); end
            end
            next_cycle();
        end
        req_valid = '0;
    endtask

    task automatic test_credit_limit();
        logic [3:0] exp_g;
        apply_reset();
        req_valid = 4'b0100;
        for (int k = 0; k <= 64; k++) begin
            #1;
            exp_g = (k < 64) ? 4'b0100 : 4'b0000;
            checks++; if (req_ready !== exp_g) begin errors++; $display("FAIL credit_grant[%0d]: got %0h expected %0h", k, req_ready, exp_g); end
            if (k != 64) next_cycle();
        end
        checks++; if (tx_valid !== 1'b1) begin errors++; $display("FAIL credit_last_tx: got %0b expected 1", tx_valid); end
        rx_valid = 1'b1; rx_mdata = {3'd2, 13'h0055}; rx_data = {16{32'hCAFE0002}};
        next_cycle();
        rx_valid = 1'b0;
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL credit_regrant: got %0h expected 4", req_ready); end
        checks++; if (resp_valid !== 4'b0100) begin errors++; $display("FAIL credit_resp_valid: got %0h expected 4", resp_valid); end
        checks++; if (resp_tag !== 13'h0055) begin errors++; $display("FAIL credit_resp_tag: got %0h expected 55", resp_tag); end
        checks++; if (tag_err !== 1'b0) begin errors++; $display("FAIL credit_tag_err: got %0b expected 0", tag_err); end
        next_cycle();
        req_valid = '0;
    endtask

    task automatic test_same_cycle();
        logic [3:0]   exp_g;
        logic [511:0] pat;
        pat = {16{32'h1234_00AB}};
        apply_reset();
        req_valid = 4'b0100;
        for (int k = 0; k <= 65; k++) begin
            #1;
            if (k == 10) begin
                rx_valid = 1'b1; rx_mdata = {3'd2, 13'h0ABC}; rx_data = pat;
            end
            exp_g = (k <= 64) ? 4'b0100 : 4'b0000;
            checks++; if (req_ready !== exp_g) begin errors++; $display("FAIL same_grant[%0d]: got %0h expected %0h", k, req_ready, exp_g); end
            if (k == 11) begin
                checks++; if (resp_valid !== 4'b0100) begin errors++; $display("FAIL same_resp_valid: got %0h expected 4", resp_valid); end
                checks++; if (resp_tag !== 13'h0ABC) begin errors++; $display("FAIL same_resp_tag: got %0h expected abc", resp_tag); end
                checks++; if (resp_data !== pat) begin errors++; $display("FAIL same_resp_data: got %0h expected %0h", resp_data[31:0], pat[31:0]); end
            end
            next_cycle();
            rx_valid = 1'b0;
        end
        checks++; if (tag_err !== 1'b0) begin errors++; $display("FAIL same_tag_err: got %0b expected 0", tag_err); end
        req_valid = '0;
    endtask

    task automatic test_almost_full();
        apply_reset();
        req_valid = 4'hF;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL af_first_grant: got %0h expected 1", req_ready); end
        next_cycle();
        tx_almostFull = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            #1;
            checks++; if (req_ready !== 4'h0) begin errors++; $display("FAIL af_blocked[%0d]: got %0h expected 0", k, req_ready); end
            checks++; if (tx_valid !== (k == 1)) begin errors++; $display("FAIL af_tx_valid[%0d]: got %0b expected %0b", k, tx_valid, (k == 1)); end
            if (k == 1) begin
                checks++; if (tx_mdata !== md_of(0)) begin errors++; $display("FAIL af_tx_mdata: got %0h expected %0h", tx_mdata, md_of(0)); end
            end
            next_cycle();
        end
        tx_almostFull = 1'b0;
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL af_resume: got %0h expected 2", req_ready); end
        next_cycle();
        #1;
        checks++; if (tx_valid !== 1'b1) begin errors++; $display("FAIL af_resume_tx: got %0b expected 1", tx_valid); end
        checks++; if (tx_mdata !== md_of(1)) begin errors++; $display("FAIL af_resume_mdata: got %0h expected %0h", tx_mdata, md_of(1)); end
        req_valid = '0;
    endtask

    task automatic test_drain();
        apply_reset();
        req_valid = 4'b0001;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL drain_pre_grant[%0d]: got %0h expected 1", k, req_ready); end
            next_cycle();
        end
        drain_req = 1'b1;
        #1;
        checks++; if (req_ready !== 4'h0) begin errors++; $display("FAIL drain_stop_grant: got %0h expected 0", req_ready); end
        checks++; if (tx_valid !== 1'b1) begin errors++; $display("FAIL drain_last_tx: got %0b expected 1", tx_valid); end
        next_cycle();
        #1;
        checks++; if (req_ready !== 4'h0) begin errors++; $display("FAIL drain_no_grant: got %0h expected 0", req_ready); end
        checks++; if (drained !== 1'b0) begin errors++; $display("FAIL drain_early0: got %0b expected 0", drained); end
        next_cycle();
        for (int k = 0; k < 3; k++) begin
            rx_valid = 1'b1; rx_mdata = {3'd0, 13'(k)};
            #1;
            checks++; if (drained !== 1'b0) begin errors++; $display("FAIL drain_busy[%0d]: got %0b expected 0", k, drained); end
            next_cycle();
        end
        rx_valid = 1'b0;
        #1;
        checks++; if (drained !== 1'b0) begin errors++; $display("FAIL drain_last_resp: got %0b expected 0", drained); end
        checks++; if (resp_valid !== 4'b0001) begin errors++; $display("FAIL drain_resp_valid: got %0h expected 1", resp_valid); end
        next_cycle();
        #1;
        checks++; if (drained !== 1'b1) begin errors++; $display("FAIL drain_done: got %0b expected 1", drained); end
        checks++; if (req_ready !== 4'h0) begin errors++; $display("FAIL drain_idle_grant: got %0h expected 0", req_ready); end
        next_cycle();
        drain_req = 1'b0;
        #1;
        checks++; if (drained !== 1'b1) begin errors++; $display("FAIL drain_release_hold: got %0b expected 1", drained); end
        checks++; if (req_ready !== 4'h0) begin errors++; $display("FAIL drain_release_grant: got %0h expected 0", req_ready); end
        next_cycle();
        #1;
        checks++; if (drained !== 1'b0) begin errors++; $display("FAIL drain_cleared: got %0b expected 0", drained); end
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL drain_resume: got %0h expected 1", req_ready); end
        req_valid = '0;
    endtask

    task automatic test_tag_err();
        apply_reset();
        rx_valid = 1'b1; rx_mdata = {3'd5, 13'h0001}; rx_data = '1;
        #1;
        checks++; if (tag_err !== 1'b0) begin errors++; $display("FAIL tagerr_before: got %0b expected 0", tag_err); end
        next_cycle();
        rx_valid = 1'b0;
        #1;
        checks++; if (tag_err !== 1'b1) begin errors++; $display("FAIL tagerr_set: got %0b expected 1", tag_err); end
        checks++; if (resp_valid !== 4'h0) begin errors++; $display("FAIL tagerr_dropped: got %0h expected 0", resp_valid); end
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            #1;
            checks++; if (tag_err !== 1'b1) begin errors++; $display("FAIL tagerr_sticky[%0d]: got %0b expected 1", k, tag_err); end
        end
        apply_reset();
        #1;
        checks++; if (tag_err !== 1'b0) begin errors++; $display("FAIL tagerr_cleared: got %0b expected 0", tag_err); end
        rx_valid = 1'b1; rx_mdata = {3'd1, 13'h0042};
        next_cycle();
        rx_valid = 1'b0;
        #1;
        checks++; if (tag_err !== 1'b1) begin errors++; $display("FAIL tagerr_no_credit: got %0b expected 1", tag_err); end
        checks++; if (resp_valid !== 4'b0010) begin errors++; $display("FAIL tagerr_no_credit_resp: got %0h expected 2", resp_valid); end
    endtask

    task automatic test_reset_mid_traffic();
        apply_reset();
        req_valid = 4'hF;
        next_cycle();
        next_cycle();
        rx_valid = 1'b1; rx_mdata = md_of(0); rx_data = {16{32'h5A5A_0000}};
        next_cycle();
        rx_valid = 1'b0;
        #1;
        checks++; if (resp_valid !== 4'b0001) begin errors++; $display("FAIL mid_pre_resp: got %0h expected 1", resp_valid); end
        checks++; if (tx_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_tx: got %0b expected 1", tx_valid); end
        reset = 1'b1;
        #1;
        checks++; if (req_ready !== 4'h0) begin errors++; $display("FAIL mid_req_ready: got %0h expected 0", req_ready); end
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL mid_tx_valid: got %0b expected 0", tx_valid); end
        checks++; if (tx_addr !== '0) begin errors++; $display("FAIL mid_tx_addr: got %0h expected 0", tx_addr); end
        checks++; if (tx_mdata !== 16'h0) begin errors++; $display("FAIL mid_tx_mdata: got %0h expected 0", tx_mdata); end
        checks++; if (resp_valid !== 4'h0) begin errors++; $display("FAIL mid_resp_valid: got %0h expected 0", resp_valid); end
        checks++; if (resp_tag !== '0) begin errors++; $display("FAIL mid_resp_tag: got %0h expected 0", resp_tag); end
        checks++; if (resp_data !== '0) begin errors++; $display("FAIL mid_resp_data: got %0h expected 0", resp_data[31:0]); end
        checks++; if (drained !== 1'b0) begin errors++; $display("FAIL mid_drained: got %0b expected 0", drained); end
        checks++; if (tag_err !== 1'b0) begin errors++; $display("FAIL mid_tag_err: got %0b expected 0", tag_err); end
        req_valid = '0;
        apply_reset();
    endtask

    initial begin
        reset = 1'b1;
        req_valid = '0; req_addr = '0; req_tag = '0;
        tx_almostFull = 1'b0; rx_valid = 1'b0; rx_mdata = '0; rx_data = '0;
        drain_req = 1'b0;
        test_reset();
        test_round_robin();
        test_credit_limit();
        test_same_cycle();
        test_almost_full();
        test_drain();
        test_tag_err();
        test_reset_mid_traffic();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
